// File: rtl/ksa_swap_controller_if.sv
// Bundles the start/key handshake and the s_memory port seen by the
// key-scheduling controller. The controller is the master of the memory port.
interface ksa_swap_controller_if #(
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic [KEY_BYTES*8-1:0] secret_key;
    logic [7:0]             mem_addr;
    logic [7:0]             mem_wdata;
    logic                   mem_wren;
    logic [7:0]             mem_rdata;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, secret_key, mem_rdata,
        output mem_addr, mem_wdata, mem_wren, busy, done
    );

    modport slave (
        output start, secret_key, mem_rdata,
        input  mem_addr, mem_wdata, mem_wren, busy, done
    );
endinterface

// File: rtl/ksa_swap_controller.sv
// RC4 key-scheduling sequencer: walks i = 0..255 over s_memory, updating
// j = j + s[i] + key[i mod KEY_BYTES] and swapping s[i] with s[j].
// All memory-port outputs are decoded from registered state only, so there is
// no combinational path from mem_rdata back to the memory port.
module ksa_swap_controller #(
    parameter int KEY_BYTES = 3,
    parameter int RD_WAIT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ksa_swap_controller_if.master bus
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_I   = 3'd1,
        CALC_J = 3'd2,
        RD_J   = 3'd3,
        WR_I   = 3'd4,
        WR_J   = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      i_q, i_d;
    logic [7:0]      j_q, j_d;
    logic [7:0]      si_q, si_d;
    logic [7:0]      sj_q, sj_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [KW-1:0]   kidx_q, kidx_d;
    logic [7:0]      key_arr [KEY_BYTES];
    logic [7:0]      key_byte;
    logic            rd_last;

    // Key byte 0 is the most significant byte of secret_key.
    generate
        for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key
            assign key_arr[gi] = bus.secret_key[(KEY_BYTES-1-gi)*8 +: 8];
        end
    endgenerate

    // Select key[i mod KEY_BYTES] using a wrapping index instead of a divider.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = key_arr[k];
            end
        end
    end

    // Read-wait counter reaches its last cycle; rdata is captured here.
    assign rd_last = (wait_q == WW'(RD_WAIT - 1));

    // State register; reset forces IDLE so wren/busy drop immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RD_I;
            RD_I:    if (rd_last) state_d = CALC_J;
            CALC_J:  state_d = RD_J;
            RD_J:    if (rd_last) state_d = WR_I;
            WR_I:    state_d = WR_J;
            WR_J:    state_d = NEXT;
            NEXT:    state_d = (i_q == 8'd255) ? DONE : RD_I;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: indices, captured bytes, wait and key counters.
    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        si_d   = si_q;
        sj_d   = sj_q;
        kidx_d = kidx_q;
        wait_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d    = 8'd0;
                    j_d    = 8'd0;
                    kidx_d = '0;
                end
            end
            RD_I: begin
                if (rd_last) si_d = bus.mem_rdata;
                else         wait_d = wait_q + WW'(1);
            end
            CALC_J: begin
                j_d = j_q + si_q + key_byte;
            end
            RD_J: begin
                if (rd_last) sj_d = bus.mem_rdata;
                else         wait_d = wait_q + WW'(1);
            end
            NEXT: begin
                if (i_q != 8'd255) begin
                    i_d    = i_q + 8'd1;
                    kidx_d = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q    <= 8'd0;
            j_q    <= 8'd0;
            si_q   <= 8'd0;
            sj_q   <= 8'd0;
            wait_q <= '0;
            kidx_q <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            si_q   <= si_d;
            sj_q   <= sj_d;
            wait_q <= wait_d;
            kidx_q <= kidx_d;
        end
    end

    // Moore outputs. On i==j the WR_J write (old s[i]) lands last, which
    // leaves s[i] unchanged as a swap should.
    always_comb begin
        bus.mem_addr  = 8'd0;
        bus.mem_wdata = 8'd0;
        bus.mem_wren  = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            RD_I: begin
                bus.mem_addr = i_q;
                bus.busy     = 1'b1;
            end
            CALC_J: begin
                bus.busy = 1'b1;
            end
            RD_J: begin
                bus.mem_addr = j_q;
                bus.busy     = 1'b1;
            end
            WR_I: begin
                bus.mem_addr  = i_q;
                bus.mem_wdata = sj_q;
                bus.mem_wren  = 1'b1;
                bus.busy      = 1'b1;
            end
            WR_J: begin
                bus.mem_addr  = j_q;
                bus.mem_wdata = si_q;
                bus.mem_wren  = 1'b1;
                bus.busy      = 1'b1;
            end
            NEXT: begin
                bus.busy = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
